// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: instruction-class codes, R-type and
// branch selects, the internal operation enum and the control FSM states.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ALU_S_T = 2'b00,
    ALU_B_T = 2'b01,
    ALU_R_T = 2'b10,
    ALU_I_T = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    F3_ADD = 3'b000,
    F3_SUB = 3'b001,
    F3_SLT = 3'b010,
    F3_MUL = 3'b011,
    F3_XOR = 3'b100,
    F3_SRL = 3'b101,
    F3_OR  = 3'b110,
    F3_AND = 3'b111
  } func3_t;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } branch_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_SLT, OP_MUL, OP_XOR, OP_SRL, OP_OR, OP_AND
  } int_op_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EXEC, ST_MUL, ST_SHR, ST_DONE
  } state_t;

  // Collapse instruction class + func3 + branch select into one internal op.
  // Stores/immediates compute an address-style ADD; branches compare by SUB
  // (equality) or signed SLT (ordering).
  function automatic int_op_t decode_op(input logic [1:0] alu_op,
                                        input logic [2:0] func3,
                                        input logic [1:0] branch_funct);
    int_op_t op;
    op = OP_ADD;
    case (alu_op)
      ALU_B_T: op = (branch_funct == BR_LT || branch_funct == BR_GE) ? OP_SLT : OP_SUB;
      ALU_R_T: begin
        case (func3)
          F3_ADD:  op = OP_ADD;
          F3_SUB:  op = OP_SUB;
          F3_SLT:  op = OP_SLT;
          F3_MUL:  op = OP_MUL;
          F3_XOR:  op = OP_XOR;
          F3_SRL:  op = OP_SRL;
          F3_OR:   op = OP_OR;
          F3_AND:  op = OP_AND;
          default: op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between the EX-stage control FSM (master) and the
// sequential ALU (slave).
//
// Handshake: start is sampled only while busy is low; a sampled start latches
// alu_op/func3/branch_funct/op_a/op_b and raises busy on the next cycle. busy
// stays high through the single-cycle done pulse. result, zero, branch_taken
// and illegal are valid from the done cycle and hold until the next done.
// start seen while busy is dropped, never queued.
interface alu_seq_unit_if #(
  parameter int XLEN = 16
);
  import alu_seq_pkg::*;

  logic            start;
  logic [1:0]      alu_op;
  logic [2:0]      func3;
  logic [1:0]      branch_funct;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            branch_taken;
  logic            illegal;
  state_t          state_dbg;

  modport master (
    output start, alu_op, func3, branch_funct, op_a, op_b,
    input  busy, done, result, zero, branch_taken, illegal, state_dbg
  );

  modport slave (
    input  start, alu_op, func3, branch_funct, op_a, op_b,
    output busy, done, result, zero, branch_taken, illegal, state_dbg
  );

endinterface

// File: rtl/alu_iter_core.sv
// Iterative engine for MUL (shift-add, one multiplier bit per cycle) and SRL
// (up to SHIFT_STEP bit positions per cycle). Loads on go; fin rises after
// the last iteration and stays high until the next go.
module alu_iter_core #(
  parameter int XLEN       = 16,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            is_mul,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            fin,
  output logic [XLEN-1:0] res
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);
  localparam logic [CW-1:0] XLEN_C = CW'(XLEN);

  logic            mode_mul;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [CW-1:0]   cnt;   // MUL: bits left; SRL: bit positions left
  logic [CW-1:0]   amt;
  logic [CW-1:0]   step;

  assign res = acc;

  // Work retired this cycle; the final SRL step may be partial.
  always_comb begin
    amt = {1'b0, b[SHW-1:0]};
    if (mode_mul) step = {{(CW-1){1'b0}}, 1'b1};
    else          step = (cnt < STEP_C) ? cnt : STEP_C;
  end

  // Load on go, then iterate until the counter drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_mul <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      fin      <= 1'b0;
    end else if (go) begin
      mode_mul <= is_mul;
      mcand    <= a;
      mplier   <= b;
      if (is_mul) begin
        acc <= '0;
        cnt <= XLEN_C;
        fin <= 1'b0;
      end else begin
        acc <= a;
        cnt <= amt;
        fin <= (amt == '0);
      end
    end else if (cnt != '0) begin
      if (mode_mul) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end else begin
        acc <= acc >> step;
      end
      cnt <= cnt - step;
      fin <= (cnt == step);
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multicycle ALU with built-in operation decode. Single-cycle ops go
// IDLE->EXEC->DONE; MUL and SRL hand off to alu_iter_core and wait for fin.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 16,
  parameter int SHIFT_STEP = 1,
  parameter int MUL_EN     = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_unit_if.slave  bus
);

  state_t          state, state_next;
  int_op_t         op_dec, op_q;
  logic            is_branch_q;
  logic [1:0]      br_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            accept, core_go, core_fin;
  logic [XLEN-1:0] core_res, exec_res, final_res;
  logic            lt, taken_c, illegal_c;

  assign accept  = (state == ST_IDLE) && bus.start;
  assign op_dec  = decode_op(bus.alu_op, bus.func3, bus.branch_funct);
  assign core_go = accept && ((op_dec == OP_SRL) || ((op_dec == OP_MUL) && (MUL_EN != 0)));

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.state_dbg = state;

  alu_iter_core #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .go     (core_go),
    .is_mul (op_dec == OP_MUL),
    .a      (bus.op_a),
    .b      (bus.op_b),
    .fin    (core_fin),
    .res    (core_res)
  );

  // Latch operands and decode at the accepted start; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_ADD;
      is_branch_q <= 1'b0;
      br_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
    end else if (accept) begin
      op_q        <= op_dec;
      is_branch_q <= (bus.alu_op == ALU_B_T);
      br_q        <= bus.branch_funct;
      a_q         <= bus.op_a;
      b_q         <= bus.op_b;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state; a disabled MUL takes the EXEC path and flags illegal.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_dec == OP_SRL)                           state_next = ST_SHR;
          else if ((op_dec == OP_MUL) && (MUL_EN != 0))   state_next = ST_MUL;
          else                                            state_next = ST_EXEC;
        end
      end
      ST_EXEC:        state_next = ST_DONE;
      ST_MUL, ST_SHR: if (core_fin) state_next = ST_DONE;
      ST_DONE:        state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // Single-cycle datapath, branch outcome and result source select.
  always_comb begin
    lt       = $signed(a_q) < $signed(b_q);
    exec_res = '0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_SLT:  exec_res = {{(XLEN-1){1'b0}}, lt};
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_AND:  exec_res = a_q & b_q;
      default: exec_res = '0;
    endcase
    taken_c = 1'b0;
    if (is_branch_q) begin
      case (br_q)
        BR_EQ:   taken_c = (a_q == b_q);
        BR_NE:   taken_c = (a_q != b_q);
        BR_LT:   taken_c = lt;
        default: taken_c = !lt;
      endcase
    end
    illegal_c = (op_q == OP_MUL) && (MUL_EN == 0);
    final_res = (state == ST_EXEC) ? exec_res : core_res;
  end

  // Response registers change only on entry to DONE and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result       <= '0;
      bus.zero         <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.illegal      <= 1'b0;
    end else if (state_next == ST_DONE) begin
      bus.result       <= final_res;
      bus.zero         <= (final_res == '0);
      bus.branch_taken <= taken_c;
      bus.illegal      <= illegal_c;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: one instance with SHIFT_STEP=4/MUL_EN=1 and one with
// SHIFT_STEP=1/MUL_EN=0. Directed table, hand sequences, then random ops
// against a plain-arithmetic reference model.
module tb_alu_seq_unit;

  localparam int XLEN = 16;

  logic clk;
  logic rst;

  alu_seq_unit_if #(.XLEN(XLEN)) bus ();
  alu_seq_unit_if #(.XLEN(XLEN)) bus_nm ();

  alu_seq_unit #(.XLEN(XLEN), .SHIFT_STEP(4), .MUL_EN(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_seq_unit #(.XLEN(XLEN), .SHIFT_STEP(1), .MUL_EN(0)) u_dut_nm (
    .clk (clk),
    .rst (rst),
    .bus (bus_nm)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- types and scoreboard ----------------
  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic        bt;
    logic        ill;
    int          lat;
    bit          timeout;
  } out_t;

  typedef struct {
    bit          nm;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [1:0]  br;
    logic [15:0] a;
    logic [15:0] b;
    out_t        exp;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_out(input string tag, input out_t got, input out_t exp);
    check({tag, " timeout"}, 32'(got.timeout), 32'(exp.timeout));
    check({tag, " result"},  32'(got.res),     32'(exp.res));
    check({tag, " zero"},    32'(got.zero),    32'(exp.zero));
    check({tag, " taken"},   32'(got.bt),      32'(exp.bt));
    check({tag, " illegal"}, 32'(got.ill),     32'(exp.ill));
    check({tag, " latency"}, 32'(got.lat),     32'(exp.lat));
  endtask

  // ---------------- reference model ----------------
  function automatic out_t ref_model(input bit nm, input logic [1:0] op, input logic [2:0] f3,
                                     input logic [1:0] br, input logic [15:0] a, input logic [15:0] b);
    out_t        r;
    int          step;
    int          amt;
    logic [31:0] prod;
    logic        lt;
    step      = nm ? 1 : 4;
    lt        = $signed(a) < $signed(b);
    r.res     = 16'h0;
    r.bt      = 1'b0;
    r.ill     = 1'b0;
    r.lat     = 2;
    r.timeout = 1'b0;
    if (op == 2'b01) begin
      case (br)
        2'b00: begin r.res = a - b; r.bt = (a == b); end
        2'b01: begin r.res = a - b; r.bt = (a != b); end
        2'b10: begin r.res = {15'h0, lt}; r.bt = lt;  end
        default: begin r.res = {15'h0, lt}; r.bt = !lt; end
      endcase
    end else if (op == 2'b10) begin
      case (f3)
        3'd0: r.res = a + b;
        3'd1: r.res = a - b;
        3'd2: r.res = {15'h0, lt};
        3'd3: begin
          if (nm) r.ill = 1'b1;
          else begin
            prod  = {16'h0, a} * {16'h0, b};
            r.res = prod[15:0];
            r.lat = XLEN + 2;
          end
        end
        3'd4: r.res = a ^ b;
        3'd5: begin
          amt   = int'(b) % XLEN;
          r.res = a >> amt;
          r.lat = (amt + step - 1) / step + 2;
        end
        3'd6: r.res = a | b;
        default: r.res = a & b;
      endcase
    end else begin
      r.res = a + b;
    end
    r.zero = (r.res == 16'h0);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit nm, input logic s, input logic [1:0] op, input logic [2:0] f3,
                        input logic [1:0] br, input logic [15:0] a, input logic [15:0] b);
    if (nm) begin
      bus_nm.start = s; bus_nm.alu_op = op; bus_nm.func3 = f3;
      bus_nm.branch_funct = br; bus_nm.op_a = a; bus_nm.op_b = b;
    end else begin
      bus.start = s; bus.alu_op = op; bus.func3 = f3;
      bus.branch_funct = br; bus.op_a = a; bus.op_b = b;
    end
  endtask

  function automatic logic get_busy(input bit nm);
    return nm ? bus_nm.busy : bus.busy;
  endfunction

  function automatic logic get_done(input bit nm);
    return nm ? bus_nm.done : bus.done;
  endfunction

  // Launch one op in an idle cycle, scramble inputs after acceptance, and
  // count clock edges (start edge included) until done is seen.
  task automatic run_op(input bit nm, input logic [1:0] op, input logic [2:0] f3,
                        input logic [1:0] br, input logic [15:0] a, input logic [15:0] b,
                        output out_t r);
    int guard;
    guard = 0;
    @(negedge clk);
    while (get_busy(nm) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    set_in(nm, 1'b1, op, f3, br, a, b);
    r.lat = 0;
    do begin
      @(posedge clk);
      #1;
      r.lat++;
      if (r.lat == 1)
        set_in(nm, 1'b0, 2'($urandom), 3'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
    end while (!get_done(nm) && r.lat < 100);
    r.timeout = !get_done(nm);
    r.res     = nm ? bus_nm.result       : bus.result;
    r.zero    = nm ? bus_nm.zero         : bus.zero;
    r.bt      = nm ? bus_nm.branch_taken : bus.branch_taken;
    r.ill     = nm ? bus_nm.illegal      : bus.illegal;
  endtask

  function automatic vec_t mk(input bit nm, input logic [1:0] op, input logic [2:0] f3,
                              input logic [1:0] br, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] res, input logic zero, input logic bt,
                              input logic ill, input int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.f3 = f3; v.br = br; v.a = a; v.b = b;
    v.exp.res = res; v.exp.zero = zero; v.exp.bt = bt; v.exp.ill = ill;
    v.exp.lat = lat; v.exp.timeout = 1'b0;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs[21];
  out_t got;
  out_t e;
  int   dcount;
  int   first_done;
  logic [15:0] exp_res;

  initial begin
    //              nm op     f3    br     a        b        res      z     bt    ill  lat
    vecs[0]  = mk(0, 2'b10, 3'd0, 2'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 2);
    vecs[1]  = mk(0, 2'b10, 3'd1, 2'd0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
    vecs[2]  = mk(0, 2'b01, 3'd0, 2'd2, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 2);
    vecs[3]  = mk(0, 2'b01, 3'd0, 2'd3, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 2);
    vecs[4]  = mk(0, 2'b01, 3'd0, 2'd0, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b1, 1'b0, 2);
    vecs[5]  = mk(0, 2'b01, 3'd0, 2'd1, 16'h0003, 16'h0004, 16'hFFFF, 1'b0, 1'b1, 1'b0, 2);
    vecs[6]  = mk(0, 2'b10, 3'd3, 2'd0, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b0, 18);
    vecs[7]  = mk(0, 2'b10, 3'd3, 2'd0, 16'h8000, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 18);
    vecs[8]  = mk(0, 2'b10, 3'd5, 2'd0, 16'hF000, 16'h000C, 16'h000F, 1'b0, 1'b0, 1'b0, 5);
    vecs[9]  = mk(0, 2'b10, 3'd5, 2'd0, 16'hF000, 16'h0000, 16'hF000, 1'b0, 1'b0, 1'b0, 2);
    vecs[10] = mk(0, 2'b10, 3'd5, 2'd0, 16'hF000, 16'h001D, 16'h0007, 1'b0, 1'b0, 1'b0, 6);
    vecs[11] = mk(0, 2'b00, 3'd5, 2'd3, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 2);
    vecs[12] = mk(0, 2'b11, 3'd3, 2'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
    vecs[13] = mk(0, 2'b10, 3'd4, 2'd0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, 2);
    vecs[14] = mk(0, 2'b10, 3'd6, 2'd0, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 2);
    vecs[15] = mk(0, 2'b10, 3'd7, 2'd0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 2);
    vecs[16] = mk(0, 2'b10, 3'd2, 2'd0, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
    vecs[17] = mk(1, 2'b10, 3'd3, 2'd0, 16'h0003, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b1, 2);
    vecs[18] = mk(1, 2'b10, 3'd5, 2'd0, 16'hF000, 16'h000C, 16'h000F, 1'b0, 1'b0, 1'b0, 14);
    vecs[19] = mk(1, 2'b10, 3'd5, 2'd0, 16'h00FF, 16'h0013, 16'h001F, 1'b0, 1'b0, 1'b0, 5);
    vecs[20] = mk(1, 2'b10, 3'd0, 2'd0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 2);

    rst = 1'b1;
    set_in(0, 1'b0, 2'b00, 3'd0, 2'd0, 16'h0, 16'h0);
    set_in(1, 1'b0, 2'b00, 3'd0, 2'd0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",      32'(bus.busy),         32'h0);
    check("reset done",      32'(bus.done),         32'h0);
    check("reset result",    32'(bus.result),       32'h0);
    check("reset zero",      32'(bus.zero),         32'h0);
    check("reset taken",     32'(bus.branch_taken), 32'h0);
    check("reset illegal",   32'(bus.illegal),      32'h0);
    check("reset nm busy",   32'(bus_nm.busy),      32'h0);
    check("reset nm result", 32'(bus_nm.result),    32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; back-to-back ops also exercise start in the idle cycle after done.
    for (int i = 0; i < 21; i++) begin
      run_op(vecs[i].nm, vecs[i].op, vecs[i].f3, vecs[i].br, vecs[i].a, vecs[i].b, got);
      compare_out($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // start held high through a MUL with operands changing under it: one done only.
    @(negedge clk);
    while (bus.busy) @(negedge clk);
    set_in(0, 1'b1, 2'b10, 3'd3, 2'd0, 16'h00FF, 16'h0101);
    dcount = 0;
    first_done = 0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        bus.op_a = 16'h1357; bus.op_b = 16'h2468; bus.func3 = 3'd0;
      end
      if (c == 10) check("held busy", 32'(bus.busy), 32'h1);
      if (bus.done) begin
        dcount++;
        if (first_done == 0) first_done = c;
      end
      if (c == 18) check("held result", 32'(bus.result), 32'hFFFF);
      if (c == 18) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    check("held done count", 32'(dcount),     32'd1);
    check("held done cycle", 32'(first_done), 32'd18);

    // Reset in the middle of a MUL: aborts immediately, no done afterwards.
    run_op(0, 2'b00, 3'd0, 2'd0, 16'h1234, 16'h0FFF, got);
    check("pre-reset result", 32'(got.res), 32'h2233);
    @(negedge clk);
    set_in(0, 1'b1, 2'b10, 3'd3, 2'd0, 16'h00FF, 16'h0101);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst busy",   32'(bus.busy),   32'h0);
    check("midrst done",   32'(bus.done),   32'h0);
    check("midrst result", 32'(bus.result), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcount++;
    end
    check("midrst no done",     32'(dcount),     32'd0);
    check("midrst result hold", 32'(bus.result), 32'h0);

    // Random ops against the reference model.
    for (int i = 0; i < 48; i++) begin
      bit          nm;
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [1:0]  br;
      logic [15:0] a;
      logic [15:0] b;
      nm = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      br = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 16'h0000;
        1:       a = 16'hFFFF;
        2:       a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 16'h7FFF;
        default: b = 16'($urandom);
      endcase
      e = ref_model(nm, op, f3, br, a, b);
      exp_q.push_back(e.res);
      run_op(nm, op, f3, br, a, b, got);
      exp_res = exp_q.pop_front();
      e.res = exp_res;
      compare_out($sformatf("rand%0d op%0d f%0d b%0d a%h b%h", i, op, f3, br, a, b), got, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
